// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    ISSUED = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned MAX_XLEN    = 64;

  // Clears the byte-offset bits of a redirect target; slice to XLEN at use.
  localparam logic [MAX_XLEN-1:0] PC_ALIGN_MASK = ~(64'(INSTR_BYTES - 1));

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch controller bus: imem req/ready/rvalid, IR load, decode/execute handshake.
interface fetch_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic            run;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_req_ready;
  logic            mem_rvalid;
  logic            ir_enable;
  logic            instr_valid;
  logic            instr_done;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc;
  logic            fetch_error;

  modport master (
    input  run, mem_req_ready, mem_rvalid, instr_done, redirect_valid, redirect_pc,
    output mem_req, mem_addr, ir_enable, instr_valid, pc, fetch_error
  );

  modport slave (
    output run, mem_req_ready, mem_rvalid, instr_done, redirect_valid, redirect_pc,
    input  mem_req, mem_addr, ir_enable, instr_valid, pc, fetch_error
  );
endinterface

// File: rtl/fetch_controller_pc_register.sv
// Program counter: aligned redirect load takes priority over sequential increment.
module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            increment,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target & PC_ALIGN_MASK[XLEN-1:0];
    end else if (increment) begin
      // Wraps modulo 2^XLEN by construction.
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: IDLE -> REQ -> WAIT -> ISSUED with redirect squash.
// Optional imem timeout (sticky fetch_error) enabled by defining FETCH_TIMEOUT_EN.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                reset,
  fetch_controller_if.master bus
);

  fetch_state_t    state_q, state_d;
  logic            squash_q, squash_d;
  logic            timeout_hit;
  logic            fetch_error_q;
  logic            pc_load, pc_inc;
  logic [XLEN-1:0] pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            fetch_error_d;

  assign timeout_hit = (state_q == WAIT) && !bus.mem_rvalid &&
                       (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d         = ((state_q == WAIT) && (state_d == WAIT)) ? tmo_q + 1'b1 : '0;
    fetch_error_d = fetch_error_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q         <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      fetch_error_q <= fetch_error_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign fetch_error_q  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    unique case (state_q)
      IDLE: begin
        // A latched fetch_error keeps the FSM parked until reset.
        if (bus.run && !fetch_error_q) state_d = REQ;
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d  = WAIT;
          squash_d = bus.redirect_valid;
        end else if (!bus.run) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          squash_d = 1'b0;
          state_d  = (squash_q || bus.redirect_valid) ? REQ : ISSUED;
        end else begin
          if (bus.redirect_valid) squash_d = 1'b1;
          if (timeout_hit) begin
            state_d  = IDLE;
            squash_d = 1'b0;
          end
        end
      end
      ISSUED: begin
        if (bus.instr_done) state_d = bus.run ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req     = (state_q == REQ);
    bus.mem_addr    = pc;
    bus.pc          = pc;
    // A redirect arriving with the data also makes that data stale.
    bus.ir_enable   = (state_q == WAIT) && bus.mem_rvalid && !squash_q && !bus.redirect_valid;
    bus.instr_valid = (state_q == ISSUED);
    bus.fetch_error = fetch_error_q;
    pc_load         = bus.redirect_valid && ((state_q != ISSUED) || bus.instr_done);
    pc_inc          = (state_q == ISSUED) && bus.instr_done && !bus.redirect_valid;
  end

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .increment (pc_inc),
    .target    (bus.redirect_pc),
    .pc        (pc)
  );

endmodule
